line_mem_responder: RTL

Synthesizable main-memory responder on the memory side of the direct-mapped cache: it accepts 128-bit line read and write requests from the cache over a valid/ready handshake and answers each one after a fixed, parameterized latency. Storage is four 32-bit word banks, one per word of a cache line, with per-byte write enables applied to every bank. It replaces the zero-latency behavioural RAMs in system benches, so miss-penalty and stall counting reflect a realistic memory.

---
 rtl/line_mem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory that answers cache line reads and writes over a valid/ready handshake.
// Optional build macro LINE_MEM_STATS_EN adds read, write and busy-cycle counters.
module line_mem_responder #(
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int INDEX_W = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              busy
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_busy_cycles
`endif
);

    localparam int         DEPTH    = 1 << INDEX_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("line_mem_responder: LATENCY must be within 1..15");
    end

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                busy_q, busy_d;
    logic [LINE_W-1:0]   rdata_q;
    logic                we_q;
    logic [3:0]          be_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                accept_s;
    logic                commit_s;
    logic [LINE_W-1:0]   rd_line_s;
    logic                unused_addr_s;

    // Offset and tag bits above the index alias onto the same line.
    assign unused_addr_s = ^{req_addr[ADDR_W-1:INDEX_W+4], req_addr[3:0]};

    assign accept_s = (state_q == IDLE) && ready_q && req_valid;
    assign commit_s = (state_q == WAIT) && (cnt_q == 4'd0);

    // State register, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            rdata_q      <= {LINE_W{1'b0}};
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            idx_q        <= {INDEX_W{1'b0}};
            wdata_q      <= {LINE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            if (accept_s) begin
                we_q    <= req_we;
                be_q    <= req_be;
                idx_q   <= req_addr[INDEX_W+3:4];
                wdata_q <= req_wdata;
            end
            if (commit_s && !we_q) begin
                rdata_q <= rd_line_s;
            end
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        ready_d      = 1'b0;
        resp_valid_d = 1'b0;
        busy_d       = 1'b1;
        case (state_d)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            WAIT:    busy_d = 1'b1;
            RESP:    resp_valid_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    // Each word bank is split into byte lanes so byte enables need no read-modify-write.
    for (genvar w = 0; w < 4; w++) begin : g_word
        for (genvar b = 0; b < 4; b++) begin : g_byte
            logic [7:0] lane_q [DEPTH];

            // Byte lane write at the commit edge; reset never clears storage.
            always_ff @(posedge clk) begin
                if (!rst && commit_s && we_q && be_q[b]) begin
                    lane_q[idx_q] <= wdata_q[32*w+8*b +: 8];
                end
            end

            assign rd_line_s[32*w+8*b +: 8] = lane_q[idx_q];
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign busy       = busy_q;

`ifdef LINE_MEM_STATS_EN
    logic [31:0] stat_reads_q;
    logic [31:0] stat_writes_q;
    logic [31:0] stat_busy_q;

    // Activity counters, wrapping modulo 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reads_q  <= 32'd0;
            stat_writes_q <= 32'd0;
            stat_busy_q   <= 32'd0;
        end else begin
            if (commit_s && !we_q) begin
                stat_reads_q <= stat_reads_q + 32'd1;
            end
            if (commit_s && we_q) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
            if (busy_q) begin
                stat_busy_q <= stat_busy_q + 32'd1;
            end
        end
    end

    assign stat_reads       = stat_reads_q;
    assign stat_writes      = stat_writes_q;
    assign stat_busy_cycles = stat_busy_q;
`endif

endmodule
